fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V single/multi-cycle core. It sits directly upstream of the decode stage. It owns the program counter and issues word reads to instruction memory over a valid/ready request channel with at most one request in flight. Returned instructions and their PCs are buffered in a 2-entry queue and presented to decode over a valid/ready handshake; a redirect from branch/jump resolution flushes everything and restarts fetch.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  fetch address (= pc)
- imem_rsp_valid  input  1  response valid (always accepted, no backpressure)
- imem_rsp_data  input  32  fetched instruction word
- redirect_valid  input  1  change of flow
- redirect_pc  input  32  new fetch address
- instr_valid  output  1  queue head valid
- instr_ready  input  1  decode consumes head
- instruction  output  32  queue head instruction; 32'h0000_0013 (NOP) when empty
- instr_pc  output  32  PC of queue head; 0 when empty
- fetch_err  output  1  misaligned redirect, sticky (only with FETCH_MISALIGN_CHECK_EN)

## Operation
- State machine: IDLE, REQ, WAIT, KILL (+ HALT with macro).
- IDLE: entered on reset; unconditionally -> REQ next cycle.
- REQ: imem_req_valid = (queue count < 2). Handshake (valid & ready): req_pc <= pc, pc <= pc + 4, -> WAIT.
- WAIT: on imem_rsp_valid push {imem_rsp_data, req_pc} into queue, -> REQ. Space is guaranteed: count < 2 at issue, only pops since.
- KILL: a request is in flight whose response is stale; on imem_rsp_valid discard it, -> REQ.
- Redirect (highest priority, any state): queue flushed, pc <= redirect_pc; next state:
  - REQ with handshake same cycle -> KILL (accepted request is stale).
  - REQ without handshake -> REQ (address changes; memory must tolerate request withdrawal on redirect).
  - WAIT with rsp_valid same cycle -> REQ, response dropped; WAIT without -> KILL.
  - KILL with rsp_valid same cycle -> REQ; without -> KILL.
  - IDLE -> REQ.
- Queue pop on instr_valid & instr_ready; push and pop same cycle allowed at count 1 or 2. Redirect in same cycle as pop: flush wins.
- pc arithmetic: 32-bit, +4 wraps 0xFFFF_FFFC -> 0x0000_0000 silently.

## Timing
- Reset values: state IDLE, pc RESET_PC, imem_req_valid 0, imem_req_addr RESET_PC, instr_valid 0, instruction 32'h13, instr_pc 0, fetch_err 0, queue empty.
- imem_req_valid/imem_req_addr combinational from registered state, pc, count; stable until handshake or redirect.
- Queue outputs registered: instruction visible the cycle after its response.
- Zero-wait memory (ready high, rsp one cycle after handshake): reset released before edge 0 -> handshake at cycle 1, rsp cycle 2, instr_valid cycle 3. Steady throughput 1 instruction per 2 cycles.
- Decode stalled: at most 2 queued; REQ holds imem_req_valid low until a pop.
- First valid instruction after redirect (zero-wait memory, no kill): 3 cycles.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0] != 0 sets fetch_err, flushes queue, enters HALT (imem_req_valid 0, in-flight response discarded, further redirects ignored) until rst.
- Undefined: no fetch_err port, no HALT state; redirect_pc[1:0] forced to 2'b00.

## Structure
- fetch_pkg: state enum, NOP_INSTR = 32'h0000_0013, queue depth constant 2.
- Sub-module fetch_queue: 2-entry 64-bit FIFO (push, pop, flush, count, head); fetch_unit holds FSM, pc, req_pc.

## Test plan
- Reset release, RESET_PC=0x100, zero-wait memory, instr_ready=1 -> addresses 0x100,0x104,0x108 in order; instr_pc matches; first instr_valid at cycle 3.
- instr_ready=0 for 10 cycles -> exactly 2 requests issued, imem_req_valid low, queue holds 0x100/0x104 unchanged; release -> in-order drain, fetch resumes at 0x108.
- Redirect to 0x400 in same cycle as request handshake -> KILL; stale response dropped; next request addr 0x400, first delivered instr_pc 0x400.
- Redirect during WAIT coincident with rsp_valid -> response dropped, queue empty next cycle, request at redirect_pc next cycle.
- pc = 0xFFFF_FFFC -> following request addr 0x0000_0000.
- Macro on: redirect_pc 0x202 -> fetch_err=1, no further requests, later redirect ignored; rst clears fetch_err. Macro off: 0x202 fetches 0x200.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
// Contents: state_t (fetch FSM states), entry_t (queued instruction + PC),
// NOP_INSTR, QUEUE_DEPTH, align_pc() helper.
// Optional HALT state exists only when FETCH_MISALIGN_CHECK_EN is defined.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          QUEUE_DEPTH = 2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        KILL
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        HALT
`endif
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundle of the fetch stage's memory, redirect and decode channels.
// Signals:
//   imem_req_valid/ready/addr  fetch request channel (fetch -> memory)
//   imem_rsp_valid/data        fetch response, never back-pressured
//   redirect_valid/pc          change of flow from branch resolution
//   instr_valid/ready          queue head handshake towards decode
//   instruction/instr_pc       queue head contents
//   fetch_err                  sticky misaligned-redirect flag (FETCH_MISALIGN_CHECK_EN only)
// Modports: master = fetch unit, slave = environment (memory + decode + branch unit).
interface fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_err;
`endif

    modport master (
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc, instr_ready,
`ifdef FETCH_MISALIGN_CHECK_EN
        output fetch_err,
`endif
        output imem_req_valid, imem_req_addr,
        output instr_valid, instruction, instr_pc
    );

    modport slave (
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc, instr_ready,
`ifdef FETCH_MISALIGN_CHECK_EN
        input  fetch_err,
`endif
        input  imem_req_valid, imem_req_addr,
        input  instr_valid, instruction, instr_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of {instruction, pc} between fetch and decode.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push, din   enqueue din (ignored when full unless a pop frees a slot)
//   pop         dequeue head (ignored when empty)
//   flush       empty the queue, overrides push and pop
//   head        oldest entry (slot 0), meaningful only when count != 0
//   count       number of valid entries (0..2)
module fetch_queue
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entry_t     din,
    output entry_t     head,
    output logic [1:0] count
);

    entry_t     slot0, slot1, slot0_n, slot1_n;
    logic [1:0] count_n, wr_idx;
    logic       do_pop, do_push;

    // Slot 0 is always the head, so a pop shifts slot 1 down and an incoming
    // word lands in the first free slot after that shift.
    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != 2'(QUEUE_DEPTH)) || do_pop);
        wr_idx  = count - {1'b0, do_pop};
        count_n = flush ? 2'd0 : count + {1'b0, do_push} - {1'b0, do_pop};
        slot0_n = (do_push && wr_idx == 2'd0) ? din : do_pop ? slot1 : slot0;
        slot1_n = (do_push && wr_idx == 2'd1) ? din : slot1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            count <= count_n;
            slot0 <= slot0_n;
            slot1 <= slot1_n;
        end
    end

    assign head = slot0;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage -- owns the PC, issues one word read at a
// time to instruction memory and queues returned words for decode.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       fetch_unit_if.master (memory request/response, redirect, decode handshake)
// Parameter RESET_PC: first fetch address after reset (word aligned).
// Macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect raises sticky fetch_err
// and parks the unit in HALT until reset; without it the low PC bits are dropped.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);

    state_t      state, state_n;
    logic [31:0] pc, pc_n, req_pc;
    logic [1:0]  count;
    entry_t      head, rsp_entry;
    logic        hs, rsp, redir, stale, push, pop;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign, err;
`endif

    assign bus.imem_req_valid = (state == REQ) && (count < 2'(QUEUE_DEPTH));
    assign bus.imem_req_addr  = pc;
    assign hs                 = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp                = bus.imem_rsp_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redir         = bus.redirect_valid && (state != HALT);
    assign misalign      = redir && (bus.redirect_pc[1:0] != 2'b00);
    assign bus.fetch_err = err;
`else
    assign redir = bus.redirect_valid;
`endif

    // A redirect leaves a stale request outstanding when one was just
    // accepted, or when one is in flight and its response has not arrived.
    assign stale = (state == REQ) ? hs : ((state == WAIT || state == KILL) && !rsp);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = REQ;
            REQ:        state_n = hs ? WAIT : REQ;
            WAIT, KILL: state_n = rsp ? REQ : state;
            default:    state_n = state;
        endcase
        if (redir)
            state_n = stale ? KILL : REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
        if (misalign)
            state_n = HALT;
`endif
    end

    assign pc_n = redir ? align_pc(bus.redirect_pc) : hs ? pc + 32'd4 : pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= '0;
        end else begin
            state  <= state_n;
            pc     <= pc_n;
            if (hs)
                req_pc <= pc;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err <= 1'b0;
        else if (misalign)
            err <= 1'b1;
    end
`endif

    // Responses are only kept in WAIT; a same-cycle redirect drops them.
    assign push      = (state == WAIT) && rsp && !redir;
    assign pop       = bus.instr_valid && bus.instr_ready;
    assign rsp_entry = '{instr: bus.imem_rsp_data, pc: req_pc};

    fetch_queue u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redir),
        .din   (rsp_entry),
        .head  (head),
        .count (count)
    );

    assign bus.instr_valid = (count != 2'd0);
    assign bus.instruction = bus.instr_valid ? head.instr : NOP_INSTR;
    assign bus.instr_pc    = bus.instr_valid ? head.pc : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a stream-level model.
module tb_fetch_unit;

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          vecs = 0;
    int          errs = 0;
    int          cyc;
    int          p_rdy, lat_max, p_ir, f_cyc;
    bit          rnd_redir, mem_busy, halted;
    int          mem_cnt;
    logic [31:0] mem_addr, exp_req, exp_del, f_pc;
    ev_t         hs_q[$];
    ev_t         del_q[$];

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
        hs_q.delete();
        del_q.delete();
        exp_req  = 32'h100;
        exp_del  = 32'h100;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        halted   = 1'b0;
        f_cyc    = -1;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_req_addr", bus.imem_req_addr, 32'h100);
        chk("rst_instr_valid", bus.instr_valid, 0);
        chk("rst_instruction", bus.instruction, 32'h13);
        chk("rst_instr_pc", bus.instr_pc, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("rst_fetch_err", bus.fetch_err, 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
    endtask

    // One clock: drive inputs after the falling edge, observe, then advance the model
    // with what the next rising edge will commit.
    task automatic cycle();
        logic        hs, del, eff;
        logic [31:0] r;
        @(negedge clk);
        bus.imem_rsp_valid = mem_busy && (mem_cnt == 0);
        bus.imem_rsp_data  = mem_busy ? mem_f(mem_addr) : $urandom;
        bus.imem_req_ready = ($urandom_range(99, 0) < p_rdy);
        bus.instr_ready    = ($urandom_range(99, 0) < p_ir);
        r = $urandom;
        if ($urandom_range(3, 0) == 0)
            r = 32'hFFFF_FFF0 | (r & 32'hF);
`ifdef FETCH_MISALIGN_CHECK_EN
        r[1:0] = 2'b00;
`endif
        if (cyc == f_cyc) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = f_pc;
        end else begin
            bus.redirect_valid = rnd_redir && ($urandom_range(99, 0) < 4);
            bus.redirect_pc    = r;
        end
        #1;
        hs  = bus.imem_req_valid && bus.imem_req_ready;
        del = bus.instr_valid && bus.instr_ready;
        eff = bus.redirect_valid && !halted;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("fetch_err", bus.fetch_err, {31'b0, halted});
`endif
        if (!bus.instr_valid) begin
            chk("empty_instruction", bus.instruction, 32'h13);
            chk("empty_instr_pc", bus.instr_pc, 0);
        end
        if (halted) begin
            chk("halt_req_valid", bus.imem_req_valid, 0);
            chk("halt_instr_valid", bus.instr_valid, 0);
        end
        if (hs) begin
            chk("one_in_flight", {31'b0, mem_busy}, 0);
            chk("req_addr", bus.imem_req_addr, exp_req);
            hs_q.push_back('{cyc, bus.imem_req_addr});
            exp_req = exp_req + 32'd4;
        end
        if (del && !eff) begin
            chk("instr_pc", bus.instr_pc, exp_del);
            chk("instruction", bus.instruction, mem_f(exp_del));
            del_q.push_back('{cyc, bus.instr_pc});
            exp_del = exp_del + 32'd4;
        end
        if (bus.imem_rsp_valid)
            mem_busy = 1'b0;
        else if (mem_busy && mem_cnt > 0)
            mem_cnt--;
        if (hs) begin
            mem_busy = 1'b1;
            mem_addr = bus.imem_req_addr;
            mem_cnt  = $urandom_range(lat_max - 1, 0);
        end
        if (eff) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (bus.redirect_pc[1:0] != 2'b00)
                halted = 1'b1;
`endif
            exp_req = {bus.redirect_pc[31:2], 2'b00};
            exp_del = exp_req;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        p_rdy = 100; lat_max = 1; p_ir = 100; rnd_redir = 1'b0;

        // zero-wait memory, decode always ready
        do_reset();
        run(10);
        chk("first_hs_cyc", hs_q[0].cyc, 1);
        chk("hs0_addr", hs_q[0].val, 32'h100);
        chk("hs1_addr", hs_q[1].val, 32'h104);
        chk("hs2_addr", hs_q[2].val, 32'h108);
        chk("first_valid_cyc", del_q[0].cyc, 3);
        chk("second_valid_cyc", del_q[1].cyc, 5);

        // decode stalled: two fetched, then fetch stops
        do_reset();
        p_ir = 0;
        run(6);
        chk("stall_head_mid", bus.instr_pc, 32'h100);
        run(6);
        chk("stall_hs_count", hs_q.size(), 2);
        chk("stall_req_valid", bus.imem_req_valid, 0);
        chk("stall_instr_valid", bus.instr_valid, 1);
        chk("stall_head_end", bus.instr_pc, 32'h100);
        p_ir = 100;
        run(10);
        chk("drain0", del_q[0].val, 32'h100);
        chk("drain1", del_q[1].val, 32'h104);
        chk("drain2", del_q[2].val, 32'h108);
        chk("resume_addr", hs_q[2].val, 32'h108);

        // redirect on the handshake cycle: stale response must be dropped
        do_reset();
        f_cyc = 1; f_pc = 32'h400;
        run(10);
        chk("kill_hs_addr", hs_q[1].val, 32'h400);
        chk("kill_hs_cyc", hs_q[1].cyc, 3);
        chk("kill_first_pc", del_q[0].val, 32'h400);
        chk("kill_first_cyc", del_q[0].cyc, 5);

        // redirect in WAIT together with the response
        do_reset();
        f_cyc = 2; f_pc = 32'h800;
        run(10);
        chk("wait_hs_addr", hs_q[1].val, 32'h800);
        chk("wait_hs_cyc", hs_q[1].cyc, 3);
        chk("wait_first_pc", del_q[0].val, 32'h800);
        chk("wait_first_cyc", del_q[0].cyc, 5);

        // PC wraps past the top of the address space
        do_reset();
        f_cyc = 1; f_pc = 32'hFFFF_FFF8;
        run(12);
        chk("wrap_fffc", hs_q[2].val, 32'hFFFF_FFFC);
        chk("wrap_zero", hs_q[3].val, 32'h0);
        chk("wrap_del_zero", del_q[2].val, 32'h0);

        // misaligned redirect
        do_reset();
        f_cyc = 2; f_pc = 32'h202;
        run(12);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("halt_hs_count", hs_q.size(), 1);
        chk("halt_err_set", bus.fetch_err, 1);
        f_cyc = cyc + 1; f_pc = 32'h300;
        run(8);
        chk("halt_redirect_ignored", hs_q.size(), 1);
        chk("halt_err_sticky", bus.fetch_err, 1);
        do_reset();
        run(4);
        chk("halt_cleared_addr", hs_q[0].val, 32'h100);
`else
        chk("misalign_hs_addr", hs_q[1].val, 32'h200);
        chk("misalign_first_pc", del_q[0].val, 32'h200);
`endif

        // randomized traffic against the stream model
        do_reset();
        p_rdy = 70; lat_max = 3; p_ir = 60; rnd_redir = 1'b1;
        run(3000);
        chk("random_progress", {31'b0, del_q.size() > 50}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
